imm_inst_encoder: RTL and testbench

- Pipelined RV32 instruction encoder; the inverse of the immediate extender.
- Packs a decoded field bundle (format, opcode, register indices, functs, 32-bit immediate) back into a 32-bit instruction word.
- Range- and alignment-checks the immediate and counts malformed requests.
- Sits in the debug/boot path: the instruction-patch and self-test sequencer drive it, and its output feeds instruction-memory writes. Valid/ready on both sides.

---
 rtl/core_pkg.sv | 50 +++++
 rtl/imm_range_check.sv | 28 ++
 rtl/imm_inst_encoder.sv | 126 ++++++++++++
 tb/tb_imm_inst_encoder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32 core definitions: instruction formats, opcodes and the field packer.
`default_nettype none

package core_pkg;

  typedef enum logic [2:0] {
    INST_I     = 3'd0,
    INST_ISTAR = 3'd1,
    INST_S     = 3'd2,
    INST_B     = 3'd3,
    INST_U     = 3'd4,
    INST_J     = 3'd5,
    INST_R     = 3'd6
  } instruction_type_e;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM = 7'h13;
  localparam logic [6:0]  STORE  = 7'h23;
  localparam logic [6:0]  BRANCH = 7'h63;
  localparam logic [6:0]  LUI    = 7'h37;
  localparam logic [6:0]  JAL    = 7'h6F;

  // Scatters the immediate into its format-specific bit positions; undefined formats yield NOP.
  function automatic logic [31:0] pack_inst(
    input logic [2:0]  op_type,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    logic [31:0] word;
    case (op_type)
      INST_I:     word = {imm[11:0], rs1, funct3, rd, opcode};
      INST_ISTAR: word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      INST_S:     word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      INST_B:     word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      INST_U:     word = {imm[31:12], rd, opcode};
      INST_J:     word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      INST_R:     word = {funct7, rs2, rs1, funct3, rd, opcode};
      default:    word = NOP;
    endcase
    return word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_range_check.sv
// Flags immediates that cannot be represented (range or alignment) in the requested format.
`default_nettype none

module imm_range_check
  import core_pkg::*;
(
  input  logic [2:0]  op_type,
  input  logic [31:0] imm,
  output logic        err
);

  always_comb begin
    err = 1'b1;
    case (op_type)
      INST_I,
      INST_S:     err = !((&imm[31:11]) || !(|imm[31:11]));
      INST_ISTAR: err = |imm[31:5];
      INST_B:     err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      INST_J:     err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      INST_U:     err = |imm[11:0];
      INST_R:     err = 1'b0;
      default:    err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_inst_encoder.sv
// Two-stage valid/ready RV32 instruction encoder with immediate checking and an error counter.
`default_nettype none

module imm_inst_encoder
  import core_pkg::*;
#(
  parameter int          CNT_W    = 8,
  parameter logic [31:0] NOP_WORD = NOP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  logic             r_s1_valid;
  logic [2:0]       r_s1_op_type;
  logic [6:0]       r_s1_opcode;
  logic [4:0]       r_s1_rd;
  logic [4:0]       r_s1_rs1;
  logic [4:0]       r_s1_rs2;
  logic [2:0]       r_s1_funct3;
  logic [6:0]       r_s1_funct7;
  logic [31:0]      r_s1_imm;
  logic             r_s1_err;
  logic             r_s2_valid;
  logic [31:0]      r_s2_inst;
  logic             r_s2_err;
  logic [CNT_W-1:0] r_err_count;

  logic w_s2_ready;
  logic w_s1_ready;
  logic w_accept;
  logic w_s1_adv;
  logic w_range_err;

  // Ready chains backwards from out_ready only, so in_ready never depends on in_valid.
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign w_accept   = in_valid && w_s1_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_ready;

  imm_range_check u_range_check (
    .op_type (in_op_type),
    .imm     (in_imm),
    .err     (w_range_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_op_type <= 3'd0;
      r_s1_opcode  <= 7'd0;
      r_s1_rd      <= 5'd0;
      r_s1_rs1     <= 5'd0;
      r_s1_rs2     <= 5'd0;
      r_s1_funct3  <= 3'd0;
      r_s1_funct7  <= 7'd0;
      r_s1_imm     <= 32'd0;
      r_s1_err     <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid   <= 1'b1;
      r_s1_op_type <= in_op_type;
      r_s1_opcode  <= in_opcode;
      r_s1_rd      <= in_rd;
      r_s1_rs1     <= in_rs1;
      r_s1_rs2     <= in_rs2;
      r_s1_funct3  <= in_funct3;
      r_s1_funct7  <= in_funct7;
      r_s1_imm     <= in_imm;
      r_s1_err     <= w_range_err;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_inst  <= 32'd0;
      r_s2_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_inst  <= r_s1_err ? NOP_WORD
                             : pack_inst(r_s1_op_type, r_s1_opcode, r_s1_rd, r_s1_rs1,
                                         r_s1_rs2, r_s1_funct3, r_s1_funct7, r_s1_imm);
      r_s2_err   <= r_s1_err;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (r_s2_valid && out_ready && r_s2_err && (r_err_count != {CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign in_ready  = w_s1_ready;
  assign out_valid = r_s2_valid;
  assign out_inst  = r_s2_inst;
  assign out_err   = r_s2_err;
  assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_imm_inst_encoder.sv
// Self-checking bench for imm_inst_encoder: vector table, directed corners, random scoreboard run.
`default_nettype none

module tb_imm_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        err_clr;
  logic [7:0]  err_count;

  imm_inst_encoder #(.CNT_W(8), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_type(in_op_type), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc = 0;
  int          mcnt = 0;
  logic        s_ov, s_err, s_ir;
  logic [31:0] s_inst;
  logic [7:0]  s_cnt;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_inst;
  logic        prev_err;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference rules: representable ranges and alignment expressed as plain integer arithmetic.
  function automatic logic model_err(input logic [2:0] t, input logic [31:0] imm);
    int s;
    s = int'(imm);
    case (t)
      3'd0, 3'd2: return (s < -2048) || (s > 2047);
      3'd1:       return imm > 32'd31;
      3'd3:       return ((imm % 2) != 0) || (s < -4096) || (s > 4095);
      3'd4:       return (imm % 4096) != 0;
      3'd5:       return ((imm % 2) != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
      3'd6:       return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_enc(input logic [2:0] t, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] base;
    logic [31:0] w;
    base = (32'(rd) << 7) | 32'(op);
    case (t)
      3'd0: w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base;
      3'd1: w = (32'(f7) << 25) | ((imm & 32'h1F) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base;
      3'd2: w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
              | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
      3'd3: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
              | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
              | (((imm >> 11) & 32'h1) << 7) | 32'(op);
      3'd4: w = (imm & 32'hFFFF_F000) | base;
      3'd5: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | base;
      3'd6: w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | base;
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  // Immediate extender used for the round-trip property.
  function automatic logic [31:0] ext_imm(input logic [31:0] inst, input logic [2:0] t);
    logic [31:0] r;
    case (t)
      3'd0: r = $signed(inst) >>> 20;
      3'd2: begin
        r = $signed(inst) >>> 25;
        r = (r << 5) | ((inst >> 7) & 32'h1F);
      end
      3'd3: begin
        r = ((inst >> 31) != 0) ? 32'hFFFF_F000 : 32'h0;
        r = r | (((inst >> 7) & 32'h1) << 11) | (((inst >> 25) & 32'h3F) << 5) | (((inst >> 8) & 32'hF) << 1);
      end
      3'd4: r = inst & 32'hFFFF_F000;
      3'd5: begin
        r = ((inst >> 31) != 0) ? 32'hFFF0_0000 : 32'h0;
        r = r | (((inst >> 12) & 32'hFF) << 12) | (((inst >> 20) & 32'h1) << 11) | (((inst >> 21) & 32'h3FF) << 1);
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // One clock: called at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic cycle();
    logic acc, drn;
    exp_t e;
    #1;
    s_ov = out_valid; s_inst = out_inst; s_err = out_err; s_cnt = err_count; s_ir = in_ready;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (prev_stall) begin
      check(s_ov == 1'b1, "hold_valid", 32'(s_ov), 32'd1);
      check(s_inst == prev_inst, "hold_inst", s_inst, prev_inst);
      check(s_err == prev_err, "hold_err", 32'(s_err), 32'(prev_err));
    end
    check(s_cnt == 8'(mcnt), "err_count", 32'(s_cnt), 32'(mcnt));
    if (drn) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_word", s_inst, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check(s_inst == e.inst, "sb_inst", s_inst, e.inst);
        check(s_err == e.err, "sb_err", 32'(s_err), 32'(e.err));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_inst = s_inst;
    prev_err = s_err;
    if (acc) begin
      e.err = model_err(in_op_type, in_imm);
      e.inst = e.err ? 32'h0000_0013
                     : model_enc(in_op_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      exp_q.push_back(e);
      n_acc++;
    end
    if (err_clr) mcnt = 0;
    else if (drn && s_err && mcnt < 255) mcnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm);
    in_op_type = t; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic rand_fields();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v = v;
      1: v = $signed(v << 20) >>> 20;
      2: v = ($signed(v << 19) >>> 19) & ~32'h1;
      3: v = ($signed(v << 11) >>> 11) & ~32'h1;
      4: v = v & 32'hFFFF_F000;
      default: v = v & 32'h3F;
    endcase
    set_fields(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), 7'($urandom), v);
  endtask

  vec_t tbl[14];
  int   n;
  int   acc0;

  initial begin
    tbl[0]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, 0};
    tbl[1]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 32'h0020_A423, 1'b0, 0};
    tbl[2]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, 0};
    tbl[3]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 0};
    tbl[4]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0, 0};
    tbl[5]  = '{3'd1, 7'h13, 5'd3, 5'd2, 5'd0, 3'd1, 7'd0, 32'h0000_0003, 32'h0031_1193, 1'b0, 0};
    tbl[6]  = '{3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0, 0};
    tbl[7]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0013, 1'b1, 1};
    tbl[8]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_0013, 1'b1, 2};
    tbl[9]  = '{3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0013, 1'b1, 3};
    tbl[10] = '{3'd1, 7'h13, 5'd3, 5'd2, 5'd0, 3'd1, 7'd0, 32'h0000_0020, 32'h0000_0013, 1'b1, 4};
    tbl[11] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0000_0013, 1'b1, 5};
    tbl[12] = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF, 32'h7FF0_0093, 1'b0, 5};
    tbl[13] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 1'b1, 6};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
    check(out_inst == 32'd0, "rst_out_inst", out_inst, 32'd0);
    check(out_err == 1'b0, "rst_out_err", 32'(out_err), 32'd0);
    check(err_count == 8'd0, "rst_err_count", 32'(err_count), 32'd0);
    check(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, one at a time, with latency and round-trip checks.
    for (int i = 0; i < 14; i++) begin
      set_fields(tbl[i].t, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      n = 0;
      do begin
        cycle();
        n++;
      end while (!s_ov && n < 6);
      check(n == 2, "latency", 32'(n), 32'd2);
      check(s_inst == tbl[i].inst, "vec_inst", s_inst, tbl[i].inst);
      check(s_err == tbl[i].err, "vec_err", 32'(s_err), 32'(tbl[i].err));
      if (!tbl[i].err && tbl[i].t != 3'd1 && tbl[i].t != 3'd6)
        check(ext_imm(s_inst, tbl[i].t) == tbl[i].imm, "round_trip", ext_imm(s_inst, tbl[i].t), tbl[i].imm);
      cycle();
      check(int'(s_cnt) == tbl[i].cnt, "vec_err_count", 32'(s_cnt), 32'(tbl[i].cnt));
    end

    // Full throughput: a request accepted every cycle with the sink always ready.
    acc0 = n_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_fields();
      cycle();
    end
    in_valid = 1'b0;
    check(n_acc - acc0 == 8, "throughput", 32'(n_acc - acc0), 32'd8);
    repeat (3) cycle();

    // Backpressure: three requests offered while the sink stalls for four cycles.
    acc0 = n_acc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (n_acc - acc0 < 3) set_fields(3'd4, 7'h37, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1) << 12);
      cycle();
    end
    check(n_acc - acc0 == 2, "bp_accepts", 32'(n_acc - acc0), 32'd2);
    check(s_ir == 1'b0, "bp_in_ready", 32'(s_ir), 32'd0);
    out_ready = 1'b1;
    n = 0;
    while (n_acc - acc0 < 3 && n < 10) begin
      cycle();
      n++;
    end
    in_valid = 1'b0;
    repeat (4) cycle();
    check(exp_q.size() == 0, "bp_drained", 32'(exp_q.size()), 32'd0);

    // Saturation: 2^8+3 malformed words.
    acc0 = n_acc;
    set_fields(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    n = 0;
    while (n_acc - acc0 < 259 && n < 400) begin
      cycle();
      n++;
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    check(s_cnt == 8'hFF, "saturate", 32'(s_cnt), 32'hFF);

    // Clear coinciding with an errored handshake.
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    err_clr = 1'b1;
    cycle();
    check(s_ov && s_err, "clr_handshake", 32'(s_ov && s_err), 32'd1);
    err_clr = 1'b0;
    cycle();
    check(s_cnt == 8'd0, "clr_priority", 32'(s_cnt), 32'd0);

    // Reset while both stages hold words.
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) cycle();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check(out_valid == 1'b0, "async_rst_valid", 32'(out_valid), 32'd0);
    check(err_count == 8'd0, "async_rst_count", 32'(err_count), 32'd0);
    exp_q.delete();
    mcnt = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    check(s_ir == 1'b1, "post_rst_in_ready", 32'(s_ir), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check(s_ov == 1'b0, "no_stale_word", 32'(s_ov), 32'd0);
    end

    // Randomized traffic with random stalls and occasional clears.
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr = ($urandom_range(0, 49) == 0);
      rand_fields();
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    err_clr = 1'b0;
    repeat (4) cycle();
    check(exp_q.size() == 0, "final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
